data_path: RTL and testbench

8-bit CPU data path: holds PC, MAR, IR, A, B and CCR, the two internal buses and the ALU. It sits directly downstream of the control unit and executes its Moore-state control word every cycle. It drives the memory address from MAR and the write data from bus1, and feeds IR and CCR back to the control unit for decode and branch decisions.

---
 rtl/data_path_pkg.sv | 43 ++++
 rtl/data_path_alu.sv | 65 ++++++
 rtl/data_path.sv | 96 +++++++++
 tb/tb_data_path.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_path_pkg
// Description : Shared encodings for the 8-bit CPU data path and control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package data_path_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        BUS1_PC   = 2'b00,
        BUS1_A    = 2'b01,
        BUS1_B    = 2'b10,
        BUS1_ZERO = 2'b11
    } bus1_sel_t;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'b00,
        BUS2_BUS1 = 2'b01,
        BUS2_MEM  = 2'b10,
        BUS2_ZERO = 2'b11
    } bus2_sel_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_INC  = 3'b100,
        ALU_DEC  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_t;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage
`default_nettype wire

// File: rtl/data_path_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 8-bit ALU with NZVC flags. AND/OR/XOR exist only
//               when DATA_PATH_LOGIC_OPS_EN is defined; otherwise they yield 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import data_path_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [2:0]        sel,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] nzvc
);

    logic [DATA_W-1:0] w_operand;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_v;
    logic              w_c;

    // INC/DEC reuse the adder/subtractor with a constant one as second operand
    always_comb begin
        w_operand = ((sel == ALU_INC) || (sel == ALU_DEC)) ? 8'h01 : y;
        w_sum     = {1'b0, x} + {1'b0, w_operand};
        w_diff    = {1'b0, x} - {1'b0, w_operand};
    end

    always_comb begin
        result = '0;
        w_v    = 1'b0;
        w_c    = 1'b0;
        case (sel)
            ALU_ADD, ALU_INC: begin
                result = w_sum[DATA_W-1:0];
                w_c    = w_sum[DATA_W];
                w_v    = (x[7] == w_operand[7]) && (w_sum[7] != x[7]);
            end
            ALU_SUB, ALU_DEC: begin
                result = w_diff[DATA_W-1:0];
                w_c    = w_diff[DATA_W];
                w_v    = (x[7] != w_operand[7]) && (w_diff[7] != x[7]);
            end
`ifdef DATA_PATH_LOGIC_OPS_EN
            ALU_AND: result = x & y;
            ALU_OR:  result = x | y;
            ALU_XOR: result = x ^ y;
`endif
            ALU_PASS: result = x;
            default:  result = '0;
        endcase
    end

    always_comb begin
        nzvc        = '0;
        nzvc[CCR_N] = result[DATA_W-1];
        nzvc[CCR_Z] = (result == '0);
        nzvc[CCR_V] = w_v;
        nzvc[CCR_C] = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/data_path.sv
`default_nettype none
// ============================================================================
// Module      : data_path
// Description : 8-bit CPU data path (PC, MAR, IR, A, B, CCR, two buses, ALU).
//               Optional logic ops: DATA_PATH_LOGIC_OPS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_path
    import data_path_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              mar_load,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic              a_load,
    input  logic              b_load,
    input  logic              ccr_load,
    input  logic [2:0]        alu_sel,
    input  logic [1:0]        bus1_sel,
    input  logic [1:0]        bus2_sel,
    input  logic [DATA_W-1:0] from_memory,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] ir,
    output logic [FLAG_W-1:0] ccr
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [FLAG_W-1:0] r_ccr;

    logic [DATA_W-1:0] w_bus1;
    logic [DATA_W-1:0] w_bus2;
    logic [DATA_W-1:0] w_alu_result;
    logic [FLAG_W-1:0] w_alu_nzvc;

    always_comb begin
        case (bus1_sel)
            BUS1_PC: w_bus1 = r_pc;
            BUS1_A:  w_bus1 = r_a;
            BUS1_B:  w_bus1 = r_b;
            default: w_bus1 = '0;
        endcase
    end

    always_comb begin
        case (bus2_sel)
            BUS2_ALU:  w_bus2 = w_alu_result;
            BUS2_BUS1: w_bus2 = w_bus1;
            BUS2_MEM:  w_bus2 = from_memory;
            default:   w_bus2 = '0;
        endcase
    end

    alu u_alu (
        .x      (w_bus1),
        .y      (r_b),
        .sel    (alu_sel),
        .result (w_alu_result),
        .nzvc   (w_alu_nzvc)
    );

    // All strobes sample the same pre-edge bus2, so self-referencing loads are safe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= '0;
            r_mar <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_ccr <= '0;
        end else begin
            if (pc_load)
                r_pc <= w_bus2;
            else if (pc_inc)
                r_pc <= r_pc + 8'd1;
            if (mar_load) r_mar <= w_bus2;
            if (ir_load)  r_ir  <= w_bus2;
            if (a_load)   r_a   <= w_bus2;
            if (b_load)   r_b   <= w_bus2;
            if (ccr_load) r_ccr <= w_alu_nzvc;
        end
    end

    assign address   = r_mar;
    assign to_memory = w_bus1;
    assign ir        = r_ir;
    assign ccr       = r_ccr;

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_path
// Description : Directed self-checking bench for data_path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_path;

    logic       clk;
    logic       reset;
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load;
    logic [2:0] alu_sel;
    logic [1:0] bus1_sel, bus2_sel;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, ir;
    logic [3:0] ccr;

    int n_compared   = 0;
    int n_mismatched = 0;

    data_path dut (
        .clk         (clk),
        .reset       (reset),
        .ir_load     (ir_load),
        .mar_load    (mar_load),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .a_load      (a_load),
        .b_load      (b_load),
        .ccr_load    (ccr_load),
        .alu_sel     (alu_sel),
        .bus1_sel    (bus1_sel),
        .bus2_sel    (bus2_sel),
        .from_memory (from_memory),
        .address     (address),
        .to_memory   (to_memory),
        .ir          (ir),
        .ccr         (ccr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0;
        a_load = 0; b_load = 0; ccr_load = 0;
        alu_sel = 3'b000; bus1_sel = 2'b00; bus2_sel = 2'b00; from_memory = 8'h00;
    endtask

    // One clock edge, then controls go idle just after it
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Read a bus1 source through to_memory
    task automatic peek(input logic [1:0] src, input string tag, input logic [7:0] exp);
        bus1_sel = src;
        #1;
        check_value(tag, to_memory, exp);
    endtask

    task automatic mem_load_a(input logic [7:0] v);
        from_memory = v; bus2_sel = 2'b10; a_load = 1; tick();
    endtask

    task automatic mem_load_b(input logic [7:0] v);
        from_memory = v; bus2_sel = 2'b10; b_load = 1; tick();
    endtask

    task automatic mem_load_pc(input logic [7:0] v);
        from_memory = v; bus2_sel = 2'b10; pc_load = 1; tick();
    endtask

    // A <= ALU(A, B) with optional flag update
    task automatic alu_to_a(input logic [2:0] op, input logic upd);
        bus1_sel = 2'b01; alu_sel = op; bus2_sel = 2'b00; a_load = 1; ccr_load = upd; tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #3;
        check_value("rst_address", address, 8'h00);
        check_value("rst_ir", ir, 8'h00);
        check_value("rst_ccr", {4'h0, ccr}, 8'h00);
        check_value("rst_to_memory", to_memory, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset mid-run
        mem_load_a(8'h55);
        from_memory = 8'h21; bus2_sel = 2'b10; mar_load = 1; ir_load = 1; tick();
        peek(2'b01, "pre_rst_a", 8'h55);
        reset = 1'b0;
        #1;
        check_value("async_rst_a", to_memory, 8'h00);
        check_value("async_rst_address", address, 8'h00);
        check_value("async_rst_ir", ir, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin pc_inc = 1; tick(); end
        peek(2'b00, "pc_after_3_inc", 8'h03);

        // Fetch sequence
        mem_load_pc(8'h10);
        bus1_sel = 2'b00; bus2_sel = 2'b01; mar_load = 1; tick();
        check_value("fetch_address", address, 8'h10);
        from_memory = 8'h86; bus2_sel = 2'b10; ir_load = 1; pc_inc = 1; tick();
        check_value("fetch_ir", ir, 8'h86);
        peek(2'b00, "fetch_pc", 8'h11);

        // Add with signed overflow
        mem_load_a(8'h7F); mem_load_b(8'h01);
        alu_to_a(3'b000, 1'b1);
        peek(2'b01, "add_result", 8'h80);
        check_value("add_ccr", {4'h0, ccr}, 8'h0A);

        // Sub: zero then borrow
        mem_load_a(8'h05); mem_load_b(8'h05);
        alu_to_a(3'b001, 1'b1);
        peek(2'b01, "sub_zero_result", 8'h00);
        check_value("sub_zero_ccr", {4'h0, ccr}, 8'h04);
        mem_load_a(8'h03);
        alu_to_a(3'b001, 1'b1);
        peek(2'b01, "sub_borrow_result", 8'hFE);
        check_value("sub_borrow_ccr", {4'h0, ccr}, 8'h09);

        // ALU write without ccr_load keeps flags; INC self-load uses old A
        alu_to_a(3'b100, 1'b0);
        peek(2'b01, "inc_self_result", 8'hFF);
        check_value("ccr_hold", {4'h0, ccr}, 8'h09);

        // DEC of zero borrows; INC of 0xFF carries out to zero
        mem_load_a(8'h00);
        alu_to_a(3'b101, 1'b1);
        peek(2'b01, "dec_zero_result", 8'hFF);
        check_value("dec_zero_ccr", {4'h0, ccr}, 8'h09);
        alu_to_a(3'b100, 1'b1);
        peek(2'b01, "inc_wrap_result", 8'h00);
        check_value("inc_wrap_ccr", {4'h0, ccr}, 8'h05);

        // DEC 0x80 -> 0x7F overflows
        mem_load_a(8'h80);
        alu_to_a(3'b101, 1'b1);
        peek(2'b01, "dec_ovf_result", 8'h7F);
        check_value("dec_ovf_ccr", {4'h0, ccr}, 8'h02);

        // PC wrap and load-over-increment priority
        mem_load_pc(8'hFF);
        pc_inc = 1; tick();
        peek(2'b00, "pc_wrap", 8'h00);
        from_memory = 8'h40; bus2_sel = 2'b10; pc_load = 1; pc_inc = 1; tick();
        peek(2'b00, "pc_load_priority", 8'h40);

        // Several strobes share one bus2 value
        from_memory = 8'h5A; bus2_sel = 2'b10; a_load = 1; b_load = 1; mar_load = 1; tick();
        check_value("multi_address", address, 8'h5A);
        peek(2'b01, "multi_a", 8'h5A);
        peek(2'b10, "multi_b", 8'h5A);
        peek(2'b11, "bus1_zero", 8'h00);

        // bus2 zero select clears a register
        bus2_sel = 2'b11; b_load = 1; tick();
        peek(2'b10, "bus2_zero_b", 8'h00);

        // Logic op depends on configuration
        mem_load_a(8'hF0); mem_load_b(8'h3C);
        alu_to_a(3'b110, 1'b1);
`ifdef DATA_PATH_LOGIC_OPS_EN
        peek(2'b01, "xor_result", 8'hCC);
        check_value("xor_ccr", {4'h0, ccr}, 8'h08);
`else
        peek(2'b01, "xor_result", 8'h00);
        check_value("xor_ccr", {4'h0, ccr}, 8'h04);
`endif

        // PASS of A leaves A unchanged and clears V/C
        mem_load_a(8'h81);
        alu_to_a(3'b111, 1'b1);
        peek(2'b01, "pass_result", 8'h81);
        check_value("pass_ccr", {4'h0, ccr}, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
